// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: MEM->WB bus layout, CP0
// register addresses ({rd,sel}), CP0 write masks and exception codes.
package wb_stage_pkg;

  // MEM->WB bus: width and field LSB offsets (MSB -> LSB order on the bus).
  localparam int WB_BUS_W      = 118;
  localparam int BUS_RF_WEN    = 117;
  localparam int BUS_WDEST_LSB = 112;
  localparam int BUS_MEMRES_LSB = 80;
  localparam int BUS_LORES_LSB = 48;
  localparam int BUS_HI_WRITE  = 47;
  localparam int BUS_LO_WRITE  = 46;
  localparam int BUS_MFHI      = 45;
  localparam int BUS_MFLO      = 44;
  localparam int BUS_MTC0      = 43;
  localparam int BUS_MFC0      = 42;
  localparam int BUS_CP0A_LSB  = 34;
  localparam int BUS_SYSCALL   = 33;
  localparam int BUS_ERET      = 32;
  localparam int BUS_PC_LSB    = 0;

  // CP0 addresses, {rd[4:0], sel[2:0]}.
  localparam logic [7:0] CP0_STATUS = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE  = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC    = {5'd14, 3'd0};
  localparam logic [7:0] CP0_COUNT  = {5'd9,  3'd0};

  // Software-writable bits: STATUS IM[15:8], EXL, IE; CAUSE IP1..0.
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  localparam logic [4:0] EXCCODE_SYS = 5'd8;

  // One cycle's worth of CP0 side effects. At most one of wen/exc/eret is
  // set; the stage resolves priority before building the request.
  typedef struct packed {
    logic        wen;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        exc;
    logic        eret;
    logic [31:0] pc;
  } cp0_req_t;

endpackage

// File: rtl/wb_stage_cp0_regs.sv
// CP0 register file: STATUS, CAUSE, EPC, COUNT.
//   clk, resetn : clock, async active-low reset
//   req         : mtc0 write / SYSCALL entry / ERET for this cycle
//   rdata       : read value for req.addr (0 for unmapped addresses)
//   epc         : current EPC, used as the ERET target
module cp0_regs
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  cp0_req_t    req,
  output logic [31:0] rdata,
  output logic [31:0] epc
);

  logic [31:0] status_r, cause_r, epc_r, count_r;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_r <= '0;
      cause_r  <= '0;
      epc_r    <= '0;
      count_r  <= '0;
    end else begin
      // Free-running; an mtc0 to COUNT below overrides the increment.
      count_r <= count_r + 32'd1;
      if (req.exc) begin
        epc_r         <= req.pc;
        cause_r[6:2]  <= EXCCODE_SYS;
        status_r[1]   <= 1'b1;
      end else if (req.eret) begin
        status_r[1]   <= 1'b0;
      end else if (req.wen) begin
        case (req.addr)
          CP0_STATUS: status_r <= (status_r & ~STATUS_WMASK) | (req.wdata & STATUS_WMASK);
          CP0_CAUSE:  cause_r  <= (cause_r  & ~CAUSE_WMASK)  | (req.wdata & CAUSE_WMASK);
          CP0_EPC:    epc_r    <= req.wdata;
          CP0_COUNT:  count_r  <= req.wdata;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (req.addr)
      CP0_STATUS: rdata = status_r;
      CP0_CAUSE:  rdata = cause_r;
      CP0_EPC:    rdata = epc_r;
      CP0_COUNT:  rdata = count_r;
      default:    rdata = '0;
    endcase
  end

  assign epc = epc_r;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage. Latches the MEM->WB bus, drives the register-file write
// port, owns HI/LO and CP0, and turns SYSCALL/ERET into a flush + redirect.
//   clk, resetn          : clock, async active-low reset
//   MEM_over, MEM_WB_bus : finished instruction offered by MEM
//   WB_allow_in/valid/over, WB_wdest : handshake and hazard info
//   rf_wen/wdest/wdata   : register-file write port
//   cancel, exc_valid, exc_pc : front-end flush and PC redirect
//   WB_pc, HI_data, LO_data   : display taps
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                MEM_over,
  input  logic [WB_BUS_W-1:0] MEM_WB_bus,
  output logic                WB_allow_in,
  output logic                WB_valid,
  output logic                WB_over,
  output logic [4:0]          WB_wdest,
  output logic                rf_wen,
  output logic [4:0]          rf_wdest,
  output logic [31:0]         rf_wdata,
  output logic                cancel,
  output logic                exc_valid,
  output logic [31:0]         exc_pc,
  output logic [31:0]         WB_pc,
  output logic [31:0]         HI_data,
  output logic [31:0]         LO_data
);

  logic [WB_BUS_W-1:0] bus_r;
  logic [31:0]         hi_r, lo_r;

  logic        rf_wen_b, hi_write, lo_write, mfhi, mflo, mtc0, mfc0, syscall, eret;
  logic [4:0]  wdest;
  logic [7:0]  cp0_addr;
  logic [31:0] mem_result, lo_result, pc;

  assign rf_wen_b   = bus_r[BUS_RF_WEN];
  assign wdest      = bus_r[BUS_WDEST_LSB +: 5];
  assign mem_result = bus_r[BUS_MEMRES_LSB +: 32];
  assign lo_result  = bus_r[BUS_LORES_LSB +: 32];
  assign hi_write   = bus_r[BUS_HI_WRITE];
  assign lo_write   = bus_r[BUS_LO_WRITE];
  assign mfhi       = bus_r[BUS_MFHI];
  assign mflo       = bus_r[BUS_MFLO];
  assign mtc0       = bus_r[BUS_MTC0];
  assign mfc0       = bus_r[BUS_MFC0];
  assign cp0_addr   = bus_r[BUS_CP0A_LSB +: 8];
  assign syscall    = bus_r[BUS_SYSCALL];
  assign eret       = bus_r[BUS_ERET];
  assign pc         = bus_r[BUS_PC_LSB +: 32];

  // Live controls; syscall > eret > mtc0.
  logic sys_live, eret_live, mtc0_live;
  assign sys_live  = WB_valid & syscall;
  assign eret_live = WB_valid & eret & ~syscall;
  assign mtc0_live = WB_valid & mtc0 & ~syscall & ~eret;

  assign cancel    = sys_live | eret_live;
  assign exc_valid = cancel;

  cp0_req_t    cp0_req;
  logic [31:0] cp0_rdata, cp0_epc;

  always_comb begin
    cp0_req       = '0;
    cp0_req.wen   = mtc0_live;
    cp0_req.addr  = cp0_addr;
    cp0_req.wdata = mem_result;
    cp0_req.exc   = sys_live;
    cp0_req.eret  = eret_live;
    cp0_req.pc    = pc;
  end

  cp0_regs u_cp0 (
    .clk    (clk),
    .resetn (resetn),
    .req    (cp0_req),
    .rdata  (cp0_rdata),
    .epc    (cp0_epc)
  );

  assign exc_pc = syscall ? EXC_ENTRY : cp0_epc;

  // bus_r follows MEM even when flushing; only the valid bit is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_r    <= '0;
      WB_valid <= 1'b0;
    end else begin
      if (MEM_over) bus_r <= MEM_WB_bus;
      WB_valid <= MEM_over & ~cancel;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (WB_valid) begin
      if (hi_write) hi_r <= mem_result;
      if (lo_write) lo_r <= lo_result;
    end
  end

  always_comb begin
    rf_wdata = mem_result;
    if (mfhi)      rf_wdata = hi_r;
    else if (mflo) rf_wdata = lo_r;
    else if (mfc0) rf_wdata = cp0_rdata;
  end

  assign rf_wen      = WB_valid & rf_wen_b & ~syscall;
  assign rf_wdest    = wdest;
  assign WB_allow_in = 1'b1;
  assign WB_over     = WB_valid;
  assign WB_wdest    = wdest & {5{WB_valid}};
  assign WB_pc       = pc;
  assign HI_data     = hi_r;
  assign LO_data     = lo_r;

endmodule
